// File: rtl/jtcps1_pkg.sv
// jtcps1_pkg: shared constants, FSM encoding and round-robin helper for the CPS1 GFX arbiter.
package jtcps1_pkg;
    localparam int NREQ   = 3;
    localparam int GFX_AW = 27;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Returns the pending requester closest after 'last' in 1->2->3->1 order
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] pend, input logic [1:0] last);
        int idx;
        rr_pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (pend[idx]) rr_pick = 2'(idx);
        end
    endfunction
endpackage

// File: rtl/jtcps1_gfx_slot.sv
// jtcps1_gfx_slot: per-requester tag/data cache entry with combinational ok and pending.
module jtcps1_gfx_slot
    import jtcps1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] addr,
    input  logic [3:0]  bank,
    input  logic        half,
    input  logic        cs,
    input  logic        grant,
    input  logic        fill,
    input  logic [31:0] fill_data,
    output logic        ok,
    output logic        pending,
    output logic [31:0] data
);
    logic [27:0] tag;
    logic        valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (grant) begin
                tag   <= {bank, addr, half};
                valid <= 1'b0;
            end
            if (fill) begin
                data  <= fill_data;
                valid <= 1'b1;
            end
        end
    end

    assign ok      = cs & valid & ({bank, addr, half} == tag);
    assign pending = cs & ~ok;
endmodule

// File: rtl/jtcps1_gfx_arbiter.sv
// jtcps1_gfx_arbiter: shares the SDRAM GFX slot among the scroll1/2/3 tilemap ROM requesters.
// Define JTCPS1_GFXARB_FIXPRIO_EN for fixed priority (scroll1 > scroll2 > scroll3) instead of round robin.
module jtcps1_gfx_arbiter
    import jtcps1_pkg::*;
#(
    parameter int            TW   = 8,
    parameter logic [TW-1:0] TOUT = TW'(255)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [22:0]       rom1_addr,
    input  logic [3:0]        rom1_bank,
    input  logic              rom1_half,
    input  logic              rom1_cs,
    output logic              rom1_ok,
    output logic [31:0]       rom1_data,
    input  logic [22:0]       rom2_addr,
    input  logic [3:0]        rom2_bank,
    input  logic              rom2_half,
    input  logic              rom2_cs,
    output logic              rom2_ok,
    output logic [31:0]       rom2_data,
    input  logic [22:0]       rom3_addr,
    input  logic [3:0]        rom3_bank,
    input  logic              rom3_half,
    input  logic              rom3_cs,
    output logic              rom3_ok,
    output logic [31:0]       rom3_data,
    output logic [GFX_AW-1:0] sdram_addr,
    output logic              sdram_half,
    output logic              sdram_cs,
    input  logic              sdram_ok,
    input  logic [31:0]       sdram_data,
    output logic              tout_err
);
    logic [NREQ-1:0][22:0] addr;
    logic [NREQ-1:0][3:0]  bank;
    logic [NREQ-1:0][31:0] data;
    logic [NREQ-1:0]       half, cs, ok, pend;
    logic [1:0]            pick, sel;
    logic [TW-1:0]         cnt;
    logic                  grant, done, abort;
    state_t                state, state_nx;

    assign addr = {rom3_addr, rom2_addr, rom1_addr};
    assign bank = {rom3_bank, rom2_bank, rom1_bank};
    assign half = {rom3_half, rom2_half, rom1_half};
    assign cs   = {rom3_cs, rom2_cs, rom1_cs};
    assign {rom3_ok, rom2_ok, rom1_ok} = ok;
    assign rom1_data = data[0];
    assign rom2_data = data[1];
    assign rom3_data = data[2];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        jtcps1_gfx_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .addr      (addr[i]),
            .bank      (bank[i]),
            .half      (half[i]),
            .cs        (cs[i]),
            .grant     (grant && pick == 2'(i)),
            .fill      (done && sel == 2'(i)),
            .fill_data (sdram_data),
            .ok        (ok[i]),
            .pending   (pend[i]),
            .data      (data[i])
        );
    end

`ifdef JTCPS1_GFXARB_FIXPRIO_EN
    assign pick = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
`else
    logic [1:0] last;

    assign pick = rr_pick(pend, last);

    // Index 0 is scroll1, so the search after reset begins at scroll2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 2'd0;
        else if (done) last <= sel;
    end
`endif

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        if (state == IDLE) begin
            grant    = |pend;
            state_nx = grant ? WAIT : IDLE;
        end else if (sdram_ok) begin
            done     = 1'b1;
            state_nx = IDLE;
        end else if (cnt <= TW'(1)) begin
            abort    = 1'b1;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'd0;
            cnt        <= '0;
            sdram_addr <= '0;
            sdram_half <= 1'b0;
            sdram_cs   <= 1'b0;
            tout_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                sel        <= pick;
                sdram_addr <= {bank[pick], addr[pick]};
                sdram_half <= half[pick];
                sdram_cs   <= 1'b1;
                cnt        <= TOUT;
            end else if (state == WAIT) begin
                cnt <= cnt - TW'(1);
            end
            if (done || abort) sdram_cs <= 1'b0;
            if (abort) tout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtcps1_gfx_arbiter.sv
// tb_jtcps1_gfx_arbiter: directed checks of hit, contention, abandon, timeout and reset for the GFX arbiter.
module tb_jtcps1_gfx_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [22:0] rom1_addr = '0, rom2_addr = '0, rom3_addr = '0;
    logic [3:0]  rom1_bank = '0, rom2_bank = '0, rom3_bank = '0;
    logic        rom1_half = 1'b0, rom2_half = 1'b0, rom3_half = 1'b0;
    logic        rom1_cs = 1'b0, rom2_cs = 1'b0, rom3_cs = 1'b0;
    logic        rom1_ok, rom2_ok, rom3_ok;
    logic [31:0] rom1_data, rom2_data, rom3_data;
    logic [26:0] sdram_addr;
    logic        sdram_half, sdram_cs, tout_err;
    logic        sdram_ok = 1'b0;
    logic [31:0] sdram_data = '0;
    logic [2:0]  oks;

    int          n_chk = 0, n_fail = 0;
    int          lat = 5, lat_cnt = 0, n;
    bit          resp_en = 1'b1, resp_fixed = 1'b0;
    logic [31:0] fixed_data = '0;
    logic [26:0] grants[$];
    logic [26:0] e[3];
    logic        prev_cs = 1'b0;

    always #5 clk = ~clk;
    assign oks = {rom3_ok, rom2_ok, rom1_ok};

    jtcps1_gfx_arbiter #(.TW(8), .TOUT(8'd10)) dut (
        .clk(clk), .rst(rst),
        .rom1_addr(rom1_addr), .rom1_bank(rom1_bank), .rom1_half(rom1_half), .rom1_cs(rom1_cs),
        .rom1_ok(rom1_ok), .rom1_data(rom1_data),
        .rom2_addr(rom2_addr), .rom2_bank(rom2_bank), .rom2_half(rom2_half), .rom2_cs(rom2_cs),
        .rom2_ok(rom2_ok), .rom2_data(rom2_data),
        .rom3_addr(rom3_addr), .rom3_bank(rom3_bank), .rom3_half(rom3_half), .rom3_cs(rom3_cs),
        .rom3_ok(rom3_ok), .rom3_data(rom3_data),
        .sdram_addr(sdram_addr), .sdram_half(sdram_half), .sdram_cs(sdram_cs),
        .sdram_ok(sdram_ok), .sdram_data(sdram_data), .tout_err(tout_err)
    );

    function automatic logic [31:0] pat(input logic [26:0] a);
        return {5'd0, a} ^ 32'hC300_0000;
    endfunction

    function automatic logic [26:0] gq(input int i);
        return i < grants.size() ? grants[i] : '1;
    endfunction

    // SDRAM model: strobe sdram_ok once sdram_cs has been high for lat cycles
    always @(negedge clk) begin
        sdram_ok = 1'b0;
        if (sdram_cs && resp_en) begin
            if (lat_cnt == lat) begin
                sdram_ok   = 1'b1;
                sdram_data = resp_fixed ? fixed_data : pat(sdram_addr);
                lat_cnt    = 0;
            end else lat_cnt++;
        end else lat_cnt = 0;
    end

    always @(negedge clk) begin
        if (sdram_cs && !prev_cs) grants.push_back(sdram_addr);
        prev_cs = sdram_cs;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ok(input int r, input int max, output int cyc);
        cyc = 0;
        while (!oks[r-1] && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_ok", oks, 3'b000);
        chk("rst_sdcs", sdram_cs, 0);
        chk("rst_terr", tout_err, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_half", sdram_half, 0);
        chk("rst_data", rom1_data, 0);

        // single request, latency 5
        rom1_addr = 23'h00100; rom1_bank = 4'h2; resp_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
        grants.delete();
        rom1_cs = 1'b1;
        #1 chk("t1_sdcs_t", sdram_cs, 0);
        step();
        chk("t1_sdcs_t1", sdram_cs, 1);
        chk("t1_addr", sdram_addr, {4'h2, 23'h00100});
        wait_ok(1, 20, n);
        chk("t1_ok_cyc", n, 6);
        chk("t1_data", rom1_data, 32'hDEADBEEF);
        chk("t1_sdcs_low", sdram_cs, 0);
        repeat (3) step();
        chk("t1_grants", grants.size(), 1);

        // hit on the latched tag
        rom1_cs = 1'b0;
        step();
        chk("hit_cs_low", rom1_ok, 0);
        rom1_cs = 1'b1;
        #1 chk("hit_same_cyc", rom1_ok, 1);
        repeat (2) step();
        chk("hit_grants", grants.size(), 1);
        chk("hit_sdcs", sdram_cs, 0);
        rom1_cs = 1'b0; resp_fixed = 1'b0;
        step();

        // three-way contention, latency 3
        lat = 3; grants.delete();
        rom1_addr = 23'h000111; rom1_bank = 4'h1;
        rom2_addr = 23'h000222; rom2_bank = 4'h2;
        rom3_addr = 23'h000333; rom3_bank = 4'h3;
        {rom1_cs, rom2_cs, rom3_cs} = 3'b111;
        n = 0;
        while (oks != 3'b111 && n < 80) begin
            step();
            n++;
        end
        chk("con_all_ok", oks, 3'b111);
`ifdef JTCPS1_GFXARB_FIXPRIO_EN
        e = '{{4'h1, 23'h000111}, {4'h2, 23'h000222}, {4'h3, 23'h000333}};
`else
        e = '{{4'h2, 23'h000222}, {4'h3, 23'h000333}, {4'h1, 23'h000111}};
`endif
        for (int i = 0; i < 3; i++) chk($sformatf("con_order%0d", i), gq(i), e[i]);
        chk("con_d1", rom1_data, pat({4'h1, 23'h000111}));
        chk("con_d2", rom2_data, pat({4'h2, 23'h000222}));
        chk("con_d3", rom3_data, pat({4'h3, 23'h000333}));
        {rom1_cs, rom2_cs, rom3_cs} = 3'b000;
        step();

        // rom2 abandons its request during WAIT
        grants.delete();
        rom2_addr = 23'h000444; rom3_addr = 23'h000555;
        {rom2_cs, rom3_cs} = 2'b11;
        step();
        chk("ab_first", sdram_addr, {4'h2, 23'h000444});
        step();
        rom2_cs = 1'b0;
        wait_ok(3, 40, n);
        chk("ab_r3_ok", rom3_ok, 1);
        chk("ab_grants", grants.size(), 2);
        chk("ab_second", gq(1), {4'h3, 23'h000555});
        chk("ab_r2_data", rom2_data, pat({4'h2, 23'h000444}));
        chk("ab_r2_nok", rom2_ok, 0);
        rom2_cs = 1'b1;
        #1 chk("ab_r2_hit", rom2_ok, 1);
        {rom2_cs, rom3_cs} = 2'b00;
        step();

        // timeout with TOUT=10, then re-grant
        resp_en = 1'b0; grants.delete();
        rom3_addr = 23'h000666;
        rom3_cs = 1'b1;
        n = 0;
        while (!sdram_cs && n < 5) begin
            step();
            n++;
        end
        chk("to_start", sdram_cs, 1);
        n = 0;
        while (sdram_cs && n < 50) begin
            step();
            n++;
        end
        chk("to_len", n, 10);
        chk("to_err", tout_err, 1);
        chk("to_nok", rom3_ok, 0);
        resp_en = 1'b1;
        step();
        chk("to_regrant", sdram_cs, 1);
        chk("to_regr_addr", gq(1), {4'h3, 23'h000666});
        wait_ok(3, 20, n);
        chk("to_ok", rom3_ok, 1);
        chk("to_data", rom3_data, pat({4'h3, 23'h000666}));
        chk("to_err_stk", tout_err, 1);
        rom3_cs = 1'b0;
        step();

        // asynchronous reset mid-WAIT
        lat = 5;
        rom1_addr = 23'h000777; rom1_bank = 4'h4;
        rom1_cs = 1'b1;
        repeat (2) step();
        chk("rw_in_wait", sdram_cs, 1);
        #2 rst = 1'b1;
        #1;
        chk("rw_sdcs", sdram_cs, 0);
        chk("rw_ok", oks, 3'b000);
        chk("rw_terr", tout_err, 0);
        chk("rw_data", rom1_data, 0);
        repeat (2) step();
        rst = 1'b0;
        wait_ok(1, 20, n);
        chk("rw_after_ok", rom1_ok, 1);
        chk("rw_after_data", rom1_data, pat({4'h4, 23'h000777}));
        rom1_cs = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
